// File: rtl/gate_vector_sequencer.sv
// Purpose: steps a small table of {exp,a,b,c} vectors into a gate-delay DUT and counts output mismatches.
// Latency: each vector takes settle+3 cycles; a run of n vectors raises done n*(settle+3)+1 cycles after leaving IDLE.
// Backpressure: none; start is ignored while busy, and abort returns the sequencer to IDLE from any active state.
module gate_vector_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int SW    = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [3:0]    cfg_vec,
    input  logic [AW:0]   num_vec,
    input  logic [SW-1:0] settle,
    input  logic          start,
    input  logic          abort,
    output logic          a,
    output logic          b,
    output logic          c,
    input  logic          dut_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] cur_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ERR_MAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    tbl [DEPTH];
    logic [AW-1:0] last_idx;
    logic [SW-1:0] settle_lat;
    logic [SW-1:0] settle_cnt;

    logic [AW:0]   n_clamp;
    logic [AW:0]   n_minus1;
    logic          accept;
    logic          aborting;
    logic          last_vec;
    logic          mismatch;
    logic [CW-1:0] err_nxt;

    // Run length is clamped to the table size; the last index is n-1.
    assign n_clamp  = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
    assign n_minus1 = n_clamp - (AW+1)'(1);
    assign accept   = (state == S_IDLE) && start && (num_vec != '0);
    assign aborting = abort && (state != S_IDLE);
    assign last_vec = (cur_idx == last_idx);

    // Case inequality so an X or Z on the DUT output is treated as a miss, never a match.
    assign mismatch = (dut_out !== tbl[cur_idx][3]);
    assign err_nxt  = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + CW'(1) : err_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every transition out of an active state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_WAIT;
            S_WAIT:   if (settle_cnt == '0) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = last_vec ? S_DONE : S_APPLY;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (aborting) state_nxt = S_IDLE;
    end

    // State-decoded outputs; an abort landing in DONE suppresses the done pulse.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE) && !abort;
    end

    // Vector table: written only while idle so a running sequence sees a stable table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_we && (state == S_IDLE)) begin
            tbl[cfg_addr] <= cfg_vec;
        end
    end

    // Run datapath: stimulus registers, settle counter, index, error count and pass flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            cur_idx    <= '0;
            last_idx   <= '0;
            settle_lat <= '0;
            settle_cnt <= '0;
        end else if (aborting) begin
            // Partial err_cnt and cur_idx are kept for inspection.
            a    <= 1'b0;
            b    <= 1'b0;
            c    <= 1'b0;
            pass <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_idx   <= n_minus1[AW-1:0];
                        settle_lat <= settle;
                        cur_idx    <= '0;
                        err_cnt    <= '0;
                        pass       <= 1'b0;
                    end
                end
                S_APPLY: begin
                    {a, b, c}  <= tbl[cur_idx][2:0];
                    settle_cnt <= settle_lat;
                end
                S_WAIT: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
                end
                S_SAMPLE: begin
                    err_cnt <= err_nxt;
                    // pass is settled on entry to DONE so it is valid alongside the done pulse.
                    if (last_vec) begin
                        pass <= (err_nxt == '0);
                    end else begin
                        cur_idx <= cur_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_vec;
    logic [3:0] num_vec;
    logic [3:0] settle;
    logic       start;
    logic       abort;
    logic       a, b, c;
    logic       dut_in;
    logic       busy, done, pass;
    logic [7:0] err_cnt;
    logic [2:0] cur_idx;

    logic [3:0] s_num;
    logic       s_start;
    logic       s_a, s_b, s_c, s_busy, s_done, s_pass;
    logic [1:0] s_err;
    logic [2:0] s_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;

    gate_vector_sequencer #(.DEPTH(8), .AW(3), .SW(4), .CW(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_vec(cfg_vec),
        .num_vec(num_vec), .settle(settle), .start(start), .abort(abort),
        .a(a), .b(b), .c(c), .dut_out(dut_in), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .cur_idx(cur_idx)
    );

    // Narrow error counter instance: fed a constant 1 against an all-zero table.
    gate_vector_sequencer #(.DEPTH(8), .AW(3), .SW(4), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_vec(4'd0),
        .num_vec(s_num), .settle(4'd0), .start(s_start), .abort(1'b0),
        .a(s_a), .b(s_b), .c(s_c), .dut_out(1'b1), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_cnt(s_err), .cur_idx(s_idx)
    );

    // Gate-level DUT (a&b)|c with 5 and 4 unit delays.
    wire ab_w;
    wire fast_out;
    assign #5 ab_w     = a & b;
    assign #4 fast_out = ab_w | c;

    // Slow DUT: same function but only visible three clocks after the inputs move.
    logic [2:0] slow_pipe = 3'b000;
    always @(posedge clk) slow_pipe <= {slow_pipe[1:0], (a & b) | c};

    always_comb begin
        case (sel)
            0:       dut_in = fast_out;
            1:       dut_in = slow_pipe[2];
            default: dut_in = 1'b1;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic load_tbl(input logic [31:0] t);
        for (int i = 0; i < 8; i++) begin
            cfg_we   = 1'b1;
            cfg_addr = 3'(i);
            cfg_vec  = t[i*4 +: 4];
            step();
        end
        cfg_we = 1'b0;
    endtask

    // Starts a run and measures edges from acceptance to done, busy cycles and done pulses.
    task automatic run_seq(input logic [3:0] nv, input logic [3:0] st, input bit poke,
                           output int cyc, output int bcnt, output int dn);
        num_vec = nv;
        settle  = st;
        start   = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        bcnt  = busy ? 1 : 0;
        dn    = 0;
        while (!done && cyc < 400) begin
            if (poke && cyc == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'd3;
                cfg_vec  = 4'b0111;
            end
            step();
            cfg_we = 1'b0;
            cyc++;
            if (busy) bcnt++;
        end
        if (done) dn = 1;
        repeat (3) begin
            step();
            if (done) dn++;
        end
    endtask

    typedef struct {
        logic [31:0] tbl;
        logic [3:0]  nv;
        logic [3:0]  st;
        int          dsel;
        int          exp_err;
        logic        exp_pass;
        int          exp_cyc;
        logic [2:0]  exp_abc;
        logic [2:0]  exp_idx;
    } vec_t;

    vec_t vt[6];

    initial begin
        int cyc, bcnt, dn, guard;

        // {exp,abc} per entry; entry i sits in bits [4i+3:4i].
        vt[0] = '{32'h000094F0, 4'd4, 4'd1, 0, 0, 1'b1, 17, 3'b001, 3'd3};
        vt[1] = '{32'h00009CF0, 4'd4, 4'd1, 0, 1, 1'b0, 17, 3'b001, 3'd3};
        vt[2] = '{32'h000094F0, 4'd4, 4'd0, 1, 4, 1'b0, 13, 3'b001, 3'd3};
        vt[3] = '{32'h000094F0, 4'd4, 4'd3, 1, 0, 1'b1, 25, 3'b001, 3'd3};
        vt[4] = '{32'hFED4B290, 4'd8, 4'd0, 0, 0, 1'b1, 25, 3'b111, 3'd7};
        vt[5] = '{32'hFED4B290, 4'd9, 4'd0, 0, 0, 1'b1, 25, 3'b111, 3'd7};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_vec = '0;
        num_vec = '0; settle = '0; start = 1'b0; abort = 1'b0;
        s_num = 4'd8; s_start = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err",  32'(err_cnt), 0);
        chk("rst_idx",  32'(cur_idx), 0);
        chk("rst_abc",  32'({a, b, c}), 0);

        // start with num_vec==0 is ignored.
        num_vec = 4'd0;
        start   = 1'b1;
        bcnt = 0; dn = 0;
        repeat (4) begin
            step();
            if (busy) bcnt++;
            if (done) dn++;
        end
        start = 1'b0;
        chk("nv0_busy", 32'(bcnt), 0);
        chk("nv0_done", 32'(dn), 0);

        for (int i = 0; i < 6; i++) begin
            sel = vt[i].dsel;
            load_tbl(vt[i].tbl);
            run_seq(vt[i].nv, vt[i].st, 1'b0, cyc, bcnt, dn);
            chk($sformatf("r%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
            chk($sformatf("r%0d_busy", i), 32'(bcnt), 32'(vt[i].exp_cyc));
            chk($sformatf("r%0d_done", i), 32'(dn), 1);
            chk($sformatf("r%0d_err", i), 32'(err_cnt), 32'(vt[i].exp_err));
            chk($sformatf("r%0d_pass", i), 32'(pass), 32'(vt[i].exp_pass));
            chk($sformatf("r%0d_abc", i), 32'({a, b, c}), 32'(vt[i].exp_abc));
            chk($sformatf("r%0d_idx", i), 32'(cur_idx), 32'(vt[i].exp_idx));
        end

        // Abort during WAIT of vector 1; vector 0 has a wrong expectation so err_cnt is 1.
        sel = 0;
        load_tbl(32'h000094F8);
        num_vec = 4'd4; settle = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (cur_idx != 3'd1 && guard < 50) begin
            step();
            guard++;
        end
        chk("ab_reach_v1", 32'(cur_idx), 1);
        step();
        chk("ab_abc_v1", 32'({a, b, c}), 32'b111);
        chk("ab_err_pre", 32'(err_cnt), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_abc", 32'({a, b, c}), 0);
        chk("ab_err_hold", 32'(err_cnt), 1);
        chk("ab_pass", 32'(pass), 0);
        dn = done ? 1 : 0;
        repeat (5) begin
            step();
            if (done || busy) dn++;
        end
        chk("ab_quiet", 32'(dn), 0);
        load_tbl(32'h000094F0);
        run_seq(4'd4, 4'd1, 1'b0, cyc, bcnt, dn);
        chk("ab_rerun_cyc", 32'(cyc), 17);
        chk("ab_rerun_err", 32'(err_cnt), 0);
        chk("ab_rerun_pass", 32'(pass), 1);

        // cfg_we during a run must not disturb the table (poke would make vector 3 abc=111, exp=0).
        run_seq(4'd4, 4'd1, 1'b1, cyc, bcnt, dn);
        chk("we_err", 32'(err_cnt), 0);
        chk("we_abc", 32'({a, b, c}), 32'b001);
        chk("we_pass", 32'(pass), 1);

        // Saturation on the 2-bit counter instance.
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 400) begin
            step();
            cyc++;
        end
        chk("sat_cyc", 32'(cyc), 25);
        chk("sat_err", 32'(s_err), 3);
        chk("sat_pass", 32'(s_pass), 0);

        // Reset mid-run: immediate return to reset state and a cleared table.
        sel = 2;
        num_vec = 4'd4; settle = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #2;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_abc", 32'({a, b, c}), 0);
        chk("mr_err", 32'(err_cnt), 0);
        step();
        rst_n = 1'b1;
        step();
        run_seq(4'd4, 4'd1, 1'b0, cyc, bcnt, dn);
        chk("mr_run_cyc", 32'(cyc), 17);
        chk("mr_run_err", 32'(err_cnt), 4);
        chk("mr_run_abc", 32'({a, b, c}), 0);
        chk("mr_run_pass", 32'(pass), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Clocked scheduler that sequences stimulus into a gate-level combinational DUT with gate delays, such as the and/or delay examples. It holds a small programmable table of input vectors with expected outputs. For each vector it drives a, b and c, waits a programmable settle time so the gate delays can resolve, samples the DUT output and counts mismatches. It sits between a bench/config master and the gate-delay datapath, and replaces hand-written #-delay stimulus blocks.

Parameters:
DEPTH, 8, number of vector table entries (power of two, ≥2)
AW, 3, table address width, equal to log2(DEPTH)
SW, 4, settle counter width
CW, 8, error counter width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  AW  table write address
cfg_vec  input  4  entry packed as {exp, a, b, c}
num_vec  input  AW+1  vectors to run, 1..DEPTH
settle  input  SW  extra settle cycles per vector
start  input  1  begin run (level sampled in IDLE)
abort  input  1  cancel run
a  output  1  DUT input a (registered)
b  output  1  DUT input b (registered)
c  output  1  DUT input c (registered)
dut_out  input  1  DUT output
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at run end
pass  output  1  high when the last completed run had err_cnt==0
err_cnt  output  CW  mismatch count of the current or last run
cur_idx  output  AW  index of the vector in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - a, b, c, busy, done, pass, err_cnt and cur_idx all 0.
  - All table entries 0.
- Table writes:
  - cfg_we in IDLE writes cfg_vec to table[cfg_addr] at the clock edge.
  - cfg_we in any other state is ignored.
- States: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 and num_vec!=0 -> APPLY.
  - On that transition: latch n=min(num_vec, DEPTH), latch s=settle, cur_idx=0, err_cnt=0, pass=0.
  - start with num_vec==0 is ignored; stay in IDLE, no done.
- APPLY (1 cycle):
  - {a,b,c} registers load table[cur_idx][2:0].
  - Settle counter loads s.
  - -> WAIT.
- WAIT:
  - Counter==0 -> SAMPLE, else decrement.
  - WAIT lasts s+1 cycles.
- SAMPLE (1 cycle):
  - Compare dut_out against table[cur_idx][3]. Any value other than an exact 0/1 match counts as a mismatch, including X or Z.
  - On mismatch, err_cnt increments and saturates at 2^CW-1.
  - If cur_idx==n-1 -> DONE, else cur_idx+1 and -> APPLY.
- DONE (1 cycle):
  - done=1.
  - pass = (err_cnt after the final compare == 0).
  - -> IDLE.
- Timing:
  - Each vector takes s+3 cycles; a run takes n*(s+3)+1 cycles from leaving IDLE to done.
  - a, b and c change only on the edge ending APPLY, so they are held stable for s+2 cycles, including the SAMPLE cycle.
- Hold behaviour:
  - a, b and c keep the last vector after the run completes.
  - err_cnt, pass and cur_idx hold until the next accepted start.
- abort=1 in any non-IDLE state:
  - Next state IDLE.
  - a, b, c cleared to 0; pass=0; no done pulse; err_cnt holds its partial value.
  - abort has priority over every other transition. It has no effect in IDLE.
- start while busy is ignored.
- start and abort together in IDLE: start is accepted.
- Reset mid-run: immediate return to the reset state. The table is cleared, so it must be reloaded.

Test Plan:
- DUT out=(a&b)|c with gate delays 5 and 4 time units, clock period 10. Load {0,000},{1,111},{0,100},{1,001}; num_vec=4; settle=1 -> done after 4*4+1=17 cycles, err_cnt=0, pass=1, final a,b,c=0,0,1.
- Same table with entry 2 written as {1,100} -> err_cnt=1, pass=0, done pulses exactly once.
- settle=0 against a DUT whose delay exceeds one clock -> a mismatch is counted. settle=3 -> err_cnt=0. Per-vector cycle count (3 vs 6) checked on busy.
- Abort during WAIT of vector 1 -> IDLE next cycle, busy=0, a=b=c=0, no done, err_cnt holds its partial value. A fresh start then runs cleanly.
- Boundaries:
  - num_vec=0 with start -> stays in IDLE, busy stays 0.
  - num_vec=DEPTH -> all 8 entries run, last cur_idx=7.
  - num_vec=DEPTH+1 -> clamped to 8.
  - cfg_we during a run does not change the table contents.
- Force dut_out constant 1 against a table of all exp=0 with CW=2, DEPTH=8 -> err_cnt saturates at 3.
